// File: rtl/minesweeper_board_cover.sv
// Cover-state memory for the minesweeper board: one 2-bit entry per cell,
// flag/open commands applied at the cursor, cursor cell read combinationally.
module minesweeper_board_cover #(
   parameter int X_SIZE = 16,
   parameter int Y_SIZE = 16,
   parameter int X_BITS = 4,
   parameter int Y_BITS = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flag,
   input  logic              open,
   input  logic [X_BITS-1:0] x_coord,
   input  logic [Y_BITS-1:0] y_coord,
   output logic [1:0]        cell_val,
   output logic              opened_cell
);

   localparam int CELLS = X_SIZE * Y_SIZE;
   localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

   localparam logic [1:0] COVERED = 2'b00;
   localparam logic [1:0] OPENED  = 2'b01;
   localparam logic [1:0] FLAGGED = 2'b10;

   logic [CELLS-1:0][1:0] cover_q;
   logic                  in_range;
   logic [IDX_W-1:0]      idx;
   logic [1:0]            cur;
   logic                  do_open;
   logic                  do_flag;

   // Off-board cursor reads as covered and blocks both commands.
   always_comb begin
      in_range = (int'(x_coord) < X_SIZE) && (int'(y_coord) < Y_SIZE);
      idx      = IDX_W'(int'(y_coord) * X_SIZE + int'(x_coord));
      cur      = in_range ? cover_q[idx] : COVERED;
      do_open  = in_range && open && !flag && (cur == COVERED);
      do_flag  = in_range && flag && !open && (cur != OPENED);
   end

   assign cell_val = cur;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cover_q     <= '0;
         opened_cell <= 1'b0;
      end else begin
         opened_cell <= do_open;
         if (do_open)
            cover_q[idx] <= OPENED;
         else if (do_flag)
            cover_q[idx] <= (cur == FLAGGED) ? COVERED : FLAGGED;
      end
   end

endmodule

// File: tb/tb_minesweeper_board_cover.sv
// Scoreboard bench for minesweeper_board_cover: stimulus pushes the expected
// post-edge cursor value and pulse, a monitor pops and compares after each edge.
module tb_minesweeper_board_cover;

   logic       clk;
   logic       reset;
   logic       flag;
   logic       open;
   logic [3:0] x_coord;
   logic [3:0] y_coord;
   logic [1:0] cell_val;
   logic       opened_cell;

   minesweeper_board_cover #(
      .X_SIZE(16), .Y_SIZE(16), .X_BITS(4), .Y_BITS(4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .flag       (flag),
      .open       (open),
      .x_coord    (x_coord),
      .y_coord    (y_coord),
      .cell_val   (cell_val),
      .opened_cell(opened_cell)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] val;
      logic       pulse;
      int         x;
      int         y;
      int         tag;
   } exp_t;

   exp_t exp_q[$];
   int   tests  = 0;
   int   fails  = 0;
   int   dut_pulses = 0;

   // Reference board: 0 covered, 1 opened, 2 flagged.
   int board[16][16];

   function automatic void model_clear();
      for (int yy = 0; yy < 16; yy++)
         for (int xx = 0; xx < 16; xx++)
            board[yy][xx] = 0;
   endfunction

   // Applies one edge of the game rules; returns whether a cell became opened.
   function automatic bit model_step(bit r, bit f, bit o, int xx, int yy);
      bit p = 0;
      if (!r) begin
         model_clear();
      end else if (f && !o) begin
         if (board[yy][xx] == 0)      board[yy][xx] = 2;
         else if (board[yy][xx] == 2) board[yy][xx] = 0;
      end else if (o && !f) begin
         if (board[yy][xx] == 0) begin
            board[yy][xx] = 1;
            p = 1;
         end
      end
      return p;
   endfunction

   task automatic push_exp(bit p, int xx, int yy, int tag);
      exp_t e;
      e.val   = 2'(board[yy][xx]);
      e.pulse = p;
      e.x     = xx;
      e.y     = yy;
      e.tag   = tag;
      exp_q.push_back(e);
   endtask

   // One clock cycle of stimulus, driven on the falling edge.
   task automatic step(bit r, bit f, bit o, int xx, int yy, int tag);
      bit p;
      @(negedge clk);
      reset   = r;
      flag    = f;
      open    = o;
      x_coord = 4'(xx);
      y_coord = 4'(yy);
      p = model_step(r, f, o, xx, yy);
      push_exp(p, xx, yy, tag);
   endtask

   // Open command issued, then reset pulled low before the edge that would take it.
   task automatic step_async_reset(int xx, int yy, int tag);
      @(negedge clk);
      reset   = 1'b1;
      flag    = 1'b0;
      open    = 1'b1;
      x_coord = 4'(xx);
      y_coord = 4'(yy);
      #2 reset = 1'b0;
      void'(model_step(1'b0, 1'b0, 1'b1, xx, yy));
      push_exp(1'b0, xx, yy, tag);
   endtask

   // Monitor: one expectation per rising edge, checked 1 time unit later.
   always @(posedge clk) begin
      #1;
      if (opened_cell === 1'b1) dut_pulses++;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         tests++;
         if (cell_val !== e.val) begin
            fails++;
            $display("FAIL cell_val tag=%0d (%0d,%0d): got %b expected %b",
                     e.tag, e.x, e.y, cell_val, e.val);
         end
         tests++;
         if (opened_cell !== e.pulse) begin
            fails++;
            $display("FAIL opened_cell tag=%0d (%0d,%0d): got %b expected %b",
                     e.tag, e.x, e.y, opened_cell, e.pulse);
         end
      end else if (opened_cell === 1'b1) begin
         tests++;
         fails++;
         $display("FAIL unexpected_pulse: got opened_cell=1 expected 0");
      end
   end

   initial begin
      int p0;
      int xx;
      int yy;
      int sel;
      reset = 1'b0; flag = 1'b0; open = 1'b0; x_coord = '0; y_coord = '0;
      model_clear();

      // Reset held from time 0.
      for (int i = 0; i < 3; i++) step(0, 0, 0, i, 0, 1);

      // Open at (3,5), then re-open.
      step(1, 0, 1, 3, 5, 10);
      step(1, 0, 0, 3, 5, 11);
      step(1, 0, 1, 3, 5, 12);
      step(1, 0, 0, 3, 5, 13);

      // Flag toggle at (0,0) with open blocked by the flag.
      step(1, 1, 0, 0, 0, 20);
      step(1, 0, 1, 0, 0, 21);
      step(1, 1, 0, 0, 0, 22);
      step(1, 0, 1, 0, 0, 23);
      step(1, 0, 0, 0, 0, 24);

      // Cursor isolation at the far corner.
      step(1, 0, 1, 15, 15, 30);
      step(1, 0, 0, 14, 15, 31);
      step(1, 0, 0, 15, 14, 32);
      step(1, 1, 0, 15, 15, 33);

      // Simultaneous flag and open.
      step(1, 1, 1, 7, 7, 40);
      step(1, 0, 0, 7, 7, 41);

      // Held command: open then flag held several cycles.
      for (int i = 0; i < 3; i++) step(1, 0, 1, 9, 1, 45);
      for (int i = 0; i < 3; i++) step(1, 1, 0, 9, 2, 46);

      // Random commands concentrated on a small window to hit every transition.
      for (int i = 0; i < 600; i++) begin
         sel = int'($urandom_range(0, 9));
         xx  = int'($urandom_range(0, 5));
         yy  = int'($urandom_range(0, 5));
         step(1, sel inside {[0:2], 8}, sel inside {[3:5], 8}, xx, yy, 50);
      end

      // Mid-stream reset, sweep every coordinate while commands are ignored.
      for (int i = 0; i < 256; i++)
         step(0, i[0], i[1], i % 16, i / 16, 60);

      // Open every cell one by one.
      @(negedge clk);
      p0 = dut_pulses;
      for (int i = 0; i < 256; i++) step(1, 0, 1, i % 16, i / 16, 70);
      step(1, 0, 0, 0, 0, 71);
      @(negedge clk);
      tests++;
      if (dut_pulses - p0 !== 256) begin
         fails++;
         $display("FAIL open_all_count: got %0d pulses expected 256", dut_pulses - p0);
      end

      // Async reset arriving during an open at (2,2), then normal operation.
      step(0, 0, 0, 2, 2, 80);
      step(1, 0, 0, 2, 2, 81);
      step_async_reset(2, 2, 82);
      step(0, 0, 0, 2, 2, 83);
      step(1, 0, 1, 2, 2, 84);
      step(1, 0, 0, 2, 2, 85);
      step(1, 1, 0, 3, 2, 86);

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
